// File: rtl/main_fsm_if.sv
// Control bundle between the multicycle datapath (master) and its main FSM (slave).
// MemReady exists only when MAIN_FSM_MEM_WAIT_EN is defined.
interface main_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
`ifdef MAIN_FSM_MEM_WAIT_EN
  logic       MemReady;
`endif
  logic       IRWrite;
  logic       AdrSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;
  logic       Illegal;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [3:0] State;

  modport master (
`ifdef MAIN_FSM_MEM_WAIT_EN
    output MemReady,
`endif
    output Op, Funct,
    input  IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, Illegal,
    input  ALUSrcA, ALUSrcB, ResultSrc, State
  );

  modport slave (
`ifdef MAIN_FSM_MEM_WAIT_EN
    input  MemReady,
`endif
    input  Op, Funct,
    output IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, Illegal,
    output ALUSrcA, ALUSrcB, ResultSrc, State
  );
endinterface

// File: rtl/main_fsm.sv
// Moore main controller for a multicycle processor (fetch/decode/execute/writeback).
// Define MAIN_FSM_MEM_WAIT_EN to stall FETCH, MEMRD and MEMWR on MemReady.
module main_fsm (
  input  logic      clk,
  input  logic      reset,
  main_fsm_if.slave bus
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMRD    = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWR    = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;
  localparam logic [3:0] UNKNOWN  = 4'd10;

  logic [3:0] cur;
  logic [3:0] nxt;
  logic       ready;
  logic       funct_unused;

  // Only the immediate flag and the load/store flag steer the controller.
  assign funct_unused = ^bus.Funct[4:1];

`ifdef MAIN_FSM_MEM_WAIT_EN
  assign ready = bus.MemReady;
`else
  assign ready = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= FETCH;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:  nxt = ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.Op)
          2'b00:   nxt = bus.Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   nxt = MEMADR;
          2'b10:   nxt = BRANCH;
          default: nxt = UNKNOWN;
        endcase
      end
      MEMADR:   nxt = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:    nxt = ready ? MEMWB : MEMRD;
      MEMWB:    nxt = FETCH;
      MEMWR:    nxt = ready ? FETCH : MEMWR;
      EXECUTER: nxt = ALUWB;
      EXECUTEI: nxt = ALUWB;
      default:  nxt = FETCH;
    endcase
  end

  // FETCH strobes track MemReady so a stalled fetch never advances the PC twice.
  always_comb begin
    bus.IRWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.NextPC    = 1'b0;
    bus.RegW      = 1'b0;
    bus.MemW      = 1'b0;
    bus.Branch    = 1'b0;
    bus.ALUOp     = 1'b0;
    bus.Illegal   = 1'b0;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    bus.ResultSrc = 2'b00;
    case (cur)
      FETCH: begin
        bus.IRWrite   = ready;
        bus.NextPC    = ready;
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      DECODE: begin
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      MEMADR: bus.ALUSrcB = 2'b01;
      MEMRD:  bus.AdrSrc  = 1'b1;
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegW      = 1'b1;
      end
      MEMWR: begin
        bus.AdrSrc = 1'b1;
        bus.MemW   = 1'b1;
      end
      EXECUTER: bus.ALUOp = 1'b1;
      EXECUTEI: begin
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 1'b1;
      end
      ALUWB: bus.RegW = 1'b1;
      BRANCH: begin
        bus.ALUSrcA   = 2'b10;
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        bus.Branch    = 1'b1;
      end
      UNKNOWN: bus.Illegal = 1'b1;
      default: ;
    endcase
  end

  assign bus.State = cur;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: stimulus pushes per-cycle expectations, a monitor pops and compares.
// Runs in both MAIN_FSM_MEM_WAIT_EN configurations.
module tb_main_fsm;

  typedef struct {
    string       name;
    logic [17:0] exp;
  } item_t;

  logic  clk = 1'b0;
  logic  reset;
  logic  chk = 1'b0;
  int    checks = 0;
  int    errors = 0;
  item_t sb[$];

  main_fsm_if bus();

  main_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Hand-written output table: {State, IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, Illegal, ALUSrcA, ALUSrcB, ResultSrc}
  function automatic logic [17:0] expVec(input logic [3:0] s, input logic rdy);
    case (s)
      4'd0:    return {4'd0,  rdy, 1'b0, rdy, 5'b00000, 2'b01, 2'b10, 2'b10};
      4'd1:    return {4'd1,  8'b0000_0000, 2'b01, 2'b10, 2'b10};
      4'd2:    return {4'd2,  8'b0000_0000, 2'b00, 2'b01, 2'b00};
      4'd3:    return {4'd3,  8'b0100_0000, 2'b00, 2'b00, 2'b00};
      4'd4:    return {4'd4,  8'b0001_0000, 2'b00, 2'b00, 2'b01};
      4'd5:    return {4'd5,  8'b0100_1000, 2'b00, 2'b00, 2'b00};
      4'd6:    return {4'd6,  8'b0000_0010, 2'b00, 2'b00, 2'b00};
      4'd7:    return {4'd7,  8'b0000_0010, 2'b00, 2'b01, 2'b00};
      4'd8:    return {4'd8,  8'b0001_0000, 2'b00, 2'b00, 2'b00};
      4'd9:    return {4'd9,  8'b0000_0100, 2'b10, 2'b01, 2'b10};
      4'd10:   return {4'd10, 8'b0000_0001, 2'b00, 2'b00, 2'b00};
      default: return 18'h3ffff;
    endcase
  endfunction

  task automatic push(input string name, input logic [17:0] exp);
    item_t it;
    it.name = name;
    it.exp  = exp;
    sb.push_back(it);
  endtask

  task automatic setReady(input logic r);
`ifdef MAIN_FSM_MEM_WAIT_EN
    bus.MemReady = r;
`else
    if (r !== 1'b1) $display("[TB] ready forced low in a build without MemReady");
`endif
  endtask

  // Monitor: compares everything queued, one tick after each falling edge or an explicit probe.
  always @(negedge clk or posedge chk) begin
    item_t       it;
    logic [17:0] act;
    #1;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      act = {bus.State, bus.IRWrite, bus.AdrSrc, bus.NextPC, bus.RegW, bus.MemW, bus.Branch,
             bus.ALUOp, bus.Illegal, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc};
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", it.name, act, it.exp);
      end
    end
  end

  // Walks one instruction starting in FETCH; Op/Funct carry junk outside DECODE and MEMADR.
  task automatic applyStimulus(input string name, input logic [1:0] op, input logic [5:0] funct,
                               input int n, input logic [3:0] seq [6]);
    for (int k = 0; k < n - 1; k++) begin
      setReady(1'b1);
      if (seq[k] == 4'd1 || seq[k] == 4'd2) begin
        bus.Op    = op;
        bus.Funct = funct;
      end else begin
        bus.Op    = ~op;
        bus.Funct = ~funct;
      end
      push($sformatf("%s[%0d]", name, k), expVec(seq[k], 1'b1));
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    bus.Op    = 2'b00;
    bus.Funct = 6'b000000;
    setReady(1'b1);
    @(negedge clk);
    push("reset_hold", expVec(4'd0, 1'b1));
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);

`ifdef MAIN_FSM_MEM_WAIT_EN
    for (int i = 0; i < 3; i++) begin
      setReady(1'b0);
      push($sformatf("fetch_stall[%0d]", i), expVec(4'd0, 1'b0));
      @(negedge clk);
    end
    applyStimulus("b_after_stall", 2'b10, 6'b000000, 4, '{4'd0, 4'd1, 4'd9, 4'd0, 4'd0, 4'd0});
`endif

    applyStimulus("ldr",   2'b01, 6'b011001, 6, '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0});
    applyStimulus("str",   2'b01, 6'b011000, 5, '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0});
    applyStimulus("addi",  2'b00, 6'b101000, 5, '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0, 4'd0});
    applyStimulus("addr",  2'b00, 6'b001000, 5, '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0, 4'd0});
    applyStimulus("b",     2'b10, 6'b000000, 4, '{4'd0, 4'd1, 4'd9, 4'd0, 4'd0, 4'd0});
    applyStimulus("undef", 2'b11, 6'b000000, 4, '{4'd0, 4'd1, 4'd10, 4'd0, 4'd0, 4'd0});

    // Abort a store while in MEMWR; the probe lands before any rising edge.
    applyStimulus("str_abort", 2'b01, 6'b011000, 4, '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0});
    push("abort_memwr", expVec(4'd5, 1'b1));
    #2 reset = 1'b0;
    push("abort_async_fetch", expVec(4'd0, 1'b1));
    chk = 1'b1;
    #1 chk = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    bus.Op    = 2'b10;
    bus.Funct = 6'b000000;
    push("abort_decode", expVec(4'd1, 1'b1));
    @(negedge clk);
    push("abort_branch", expVec(4'd9, 1'b1));
    @(negedge clk);
    push("final_fetch", expVec(4'd0, 1'b1));
    @(negedge clk);
    @(negedge clk);
    #2;

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; every state update occurs on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset; 0 = in reset.
REQ-003 SHALL have port Op, input, 2, instruction class (Instr[27:26]).
REQ-004 SHALL have port Funct, input, 6, function field (Instr[25:20]); bit5 = immediate, bit0 = load/not-store.
REQ-005 SHALL have port MemReady, input, 1, memory handshake; present only with MAIN_FSM_MEM_WAIT_EN defined.
REQ-006 SHALL have outputs IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, Illegal, each 1 bit, meanings per the Function section.
REQ-007 SHALL have outputs ALUSrcA, ALUSrcB and ResultSrc, each 2 bits, datapath mux selects.
REQ-008 SHALL have output State, 4 bits, the current state encoding, for debug.

Function
REQ-009 SHALL be a Moore FSM: all outputs are decoded from the state register only, except the MemReady gating in REQ-015.
REQ-010 SHALL use these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10.
REQ-011 SHALL follow these transitions:
- FETCH->DECODE.
- DECODE: Op=00 & Funct[5]=0 -> EXECUTER; Op=00 & Funct[5]=1 -> EXECUTEI; Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> UNKNOWN.
- MEMADR: Funct[0]=1 -> MEMRD, else -> MEMWR.
- MEMRD->MEMWB->FETCH; MEMWR->FETCH.
- EXECUTER/EXECUTEI->ALUWB->FETCH.
- BRANCH->FETCH; UNKNOWN->FETCH.
- Encodings 11-15 -> FETCH.
REQ-012 SHALL drive these output values per state; every output not listed for a state is 0:
- FETCH: IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, MemW=1.
- EXECUTER: ALUOp=1.
- EXECUTEI: ALUSrcB=01, ALUOp=1.
- ALUWB: RegW=1.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1.
- UNKNOWN: Illegal=1.
REQ-013 SHALL take these numbers of cycles per instruction from FETCH back to FETCH: load 5, store 4, data-processing 4, branch 3, undefined 3.
REQ-014 SHALL sample Op and Funct only in DECODE and MEMADR; they are ignored in all other states.

Reset
REQ-015 SHALL, while reset=0, force State=FETCH immediately without waiting for clk, and drive all outputs to the FETCH values of REQ-012; with MAIN_FSM_MEM_WAIT_EN defined, IRWrite and NextPC remain gated per REQ-017.
REQ-016 SHALL, on an asynchronous reset in any state, abandon the current instruction, and SHALL leave FETCH on the first rising clk edge after reset is released, unless MAIN_FSM_MEM_WAIT_EN holds it per REQ-017.

Configuration
REQ-017 SHALL implement macro MAIN_FSM_MEM_WAIT_EN as follows:
- Defined:
  - FETCH, MEMRD and MEMWR hold their state while MemReady=0.
  - In FETCH, IRWrite and NextPC equal MemReady, so the PC advances exactly once per fetch.
  - In MEMWR, MemW stays 1 for every hold cycle.
  - Cycle counts grow by one per wait cycle.
- Undefined: the MemReady port is absent and all transitions are unconditional per REQ-011.

Verification
REQ-018 SHALL pass: reset=0 mid-MEMWR, then released -> State=0 with no clk edge; IRWrite=1 and MemW=0; DECODE follows on the first edge after release.
REQ-019 SHALL pass: LDR (Op=01, Funct=011001) -> State sequence 0,1,2,3,4,0; RegW=1 only in State 4 with ResultSrc=01.
REQ-020 SHALL pass: STR (Op=01, Funct=011000) -> State sequence 0,1,2,5,0; MemW=1 and AdrSrc=1 only in State 5.
REQ-021 SHALL pass: ADD immediate (Op=00, Funct=101000) -> State sequence 0,1,7,8,0; ALUSrcB=01 and ALUOp=1 in State 7.
REQ-022 SHALL pass: B (Op=10) -> State sequence 0,1,9,0 with Branch=1 in State 9; Op=11 -> State sequence 0,1,10,0 with Illegal=1 for exactly one cycle.
REQ-023 SHALL pass, with MAIN_FSM_MEM_WAIT_EN defined: MemReady=0 for 3 cycles in FETCH -> State stays 0 and IRWrite=NextPC=0 for those 3 cycles; IRWrite=NextPC=1 for exactly one cycle once MemReady=1.
